// File: rtl/fetch_sequencer.sv
// Instruction-cycle controller: fetches opcode and optional immediate, then
// holds the ALU or memory execute select until completion, with a per-state watchdog.
module fetch_sequencer #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fetchIn,
    input  logic        fetchPush,
    input  logic        regPush,
    output logic [1:0]  mode,
    output logic        immEn,
    output logic [31:0] fetchImm,
    output logic [31:0] instr,
    output logic        pcInc,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_OP,
        FETCH_IMM,
        EXEC_ALU,
        EXEC_MEM
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] wd, wd_next;
    logic [31:0] instr_next, imm_next;
    logic        pc_next, err_next;
    logic        in_fetch, in_exec, accept, done;

    assign in_fetch = (state == FETCH_OP) || (state == FETCH_IMM);
    assign in_exec  = (state == EXEC_ALU) || (state == EXEC_MEM);
    // A push while pcInc is high belongs to the stale PC and is dropped.
    assign accept   = in_fetch && fetchPush && !pcInc;
    assign done     = in_exec && regPush;

    always_comb begin
        state_next = state;
        instr_next = instr;
        imm_next   = fetchImm;
        pc_next    = 1'b0;
        err_next   = error;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH_OP;
                    err_next   = 1'b0;
                end
            end
            FETCH_OP: begin
                if (accept) begin
                    instr_next = fetchIn;
                    if (fetchIn == HALT_WORD) begin
                        state_next = IDLE;
                    end else begin
                        pc_next = 1'b1;
                        if (fetchIn[30]) begin
                            state_next = FETCH_IMM;
                        end else begin
                            imm_next   = '0;
                            state_next = fetchIn[31] ? EXEC_MEM : EXEC_ALU;
                        end
                    end
                end
            end
            FETCH_IMM: begin
                if (accept) begin
                    imm_next   = fetchIn;
                    pc_next    = 1'b1;
                    state_next = instr[31] ? EXEC_MEM : EXEC_ALU;
                end
            end
            EXEC_ALU, EXEC_MEM: begin
                if (done) state_next = FETCH_OP;
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything, including a start that cannot be seen while busy.
        if (state != IDLE && !accept && !done && wd == WD_LIMIT) begin
            state_next = IDLE;
            pc_next    = 1'b0;
            err_next   = 1'b1;
        end

        if (state == IDLE || state_next != state) wd_next = '0;
        else                                      wd_next = wd + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wd       <= '0;
            instr    <= '0;
            fetchImm <= '0;
            pcInc    <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            wd       <= wd_next;
            instr    <= instr_next;
            fetchImm <= imm_next;
            pcInc    <= pc_next;
            error    <= err_next;
        end
    end

    always_comb begin
        case (state)
            FETCH_OP, FETCH_IMM: mode = 2'b10;
            EXEC_ALU:            mode = 2'b00;
            EXEC_MEM:            mode = 2'b01;
            default:             mode = 2'b11;
        endcase
    end

    assign busy  = (state != IDLE);
    assign immEn = in_exec && instr[30];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed expectations across the
// instruction cycle, bubble drop, halt, watchdog abort and mid-instruction reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] fetchIn = '0;
    logic        fetchPush = 1'b0;
    logic        regPush = 1'b0;
    logic [1:0]  mode;
    logic        immEn;
    logic [31:0] fetchImm;
    logic [31:0] instr;
    logic        pcInc;
    logic        busy;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;
    int pc_count = 0;
    int pc_base  = 0;

    fetch_sequencer #(.TIMEOUT(4), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .start(start), .fetchIn(fetchIn),
        .fetchPush(fetchPush), .regPush(regPush), .mode(mode), .immEn(immEn),
        .fetchImm(fetchImm), .instr(instr), .pcInc(pcInc), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Each cycle pcInc is high is counted once, away from the active edge.
    always @(negedge clk) if (pcInc) pc_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".mode"},     32'(mode),  32'h3);
        check({tag, ".busy"},     32'(busy),  32'h0);
        check({tag, ".immEn"},    32'(immEn), 32'h0);
        check({tag, ".pcInc"},    32'(pcInc), 32'h0);
        check({tag, ".error"},    32'(error), 32'h0);
        check({tag, ".instr"},    instr,      32'h0);
        check({tag, ".fetchImm"}, fetchImm,   32'h0);
    endtask

    initial begin
        tick; tick;
        check_reset_values("reset");
        rst = 1'b0;
        tick;

        // Opcode without immediate, ALU class
        start = 1'b1; tick; start = 1'b0;
        check("t1.mode_fetch", 32'(mode), 32'h2);
        check("t1.busy", 32'(busy), 32'h1);
        pc_base = pc_count;
        fetchIn = 32'h0000_0012; fetchPush = 1'b1; tick; fetchPush = 1'b0;
        check("t1.mode_alu", 32'(mode), 32'h0);
        check("t1.instr", instr, 32'h0000_0012);
        check("t1.pcInc", 32'(pcInc), 32'h1);
        check("t1.immEn", 32'(immEn), 32'h0);
        check("t1.fetchImm", fetchImm, 32'h0);
        tick;
        check("t1.pcInc_low", 32'(pcInc), 32'h0);
        check("t1.mode_hold", 32'(mode), 32'h0);
        regPush = 1'b1; tick; regPush = 1'b0;
        check("t1.mode_back", 32'(mode), 32'h2);
        check("t1.pc_pulses", 32'(pc_count - pc_base), 32'd1);

        // Opcode with immediate, memory class, push held through the bubble
        pc_base = pc_count;
        fetchIn = 32'hC000_0005; fetchPush = 1'b1; tick;
        check("t2.mode_imm", 32'(mode), 32'h2);
        check("t2.instr", instr, 32'hC000_0005);
        check("t2.pcInc1", 32'(pcInc), 32'h1);
        fetchIn = 32'hDEAD_BEEF; tick;
        check("t2.bubble_pc", 32'(pcInc), 32'h0);
        check("t2.bubble_imm", fetchImm, 32'h0);
        check("t2.bubble_mode", 32'(mode), 32'h2);
        tick;
        check("t2.fetchImm", fetchImm, 32'hDEAD_BEEF);
        check("t2.pcInc2", 32'(pcInc), 32'h1);
        check("t2.mode_mem", 32'(mode), 32'h1);
        check("t2.immEn", 32'(immEn), 32'h1);
        tick;   // push still high, ignored in execute
        fetchPush = 1'b0;
        check("t5.push_in_exec", 32'(mode), 32'h1);
        check("t5.push_imm_kept", fetchImm, 32'hDEAD_BEEF);
        start = 1'b1; tick; start = 1'b0;
        check("t5.start_busy_mode", 32'(mode), 32'h1);
        check("t5.start_busy_immEn", 32'(immEn), 32'h1);
        regPush = 1'b1; tick; regPush = 1'b0;
        check("t2.mode_back", 32'(mode), 32'h2);
        check("t2.immEn_off", 32'(immEn), 32'h0);
        check("t2.pc_pulses", 32'(pc_count - pc_base), 32'd2);

        // regPush outside execute is ignored
        regPush = 1'b1; tick; regPush = 1'b0;
        check("t5.regpush_fetch", 32'(mode), 32'h2);

        // Halt word returns to idle without advancing PC
        pc_base = pc_count;
        fetchIn = 32'hFFFF_FFFF; fetchPush = 1'b1; tick; fetchPush = 1'b0;
        check("t3.mode", 32'(mode), 32'h3);
        check("t3.busy", 32'(busy), 32'h0);
        check("t3.instr", instr, 32'hFFFF_FFFF);
        check("t3.pcInc", 32'(pcInc), 32'h0);
        tick;
        check("t3.pc_pulses", 32'(pc_count - pc_base), 32'd0);

        // Watchdog abort in EXEC_ALU, with start coincident with the abort edge
        start = 1'b1; tick; start = 1'b0;
        fetchIn = 32'h0000_0001; fetchPush = 1'b1; tick; fetchPush = 1'b0;
        check("t4.enter_alu", 32'(mode), 32'h0);
        tick; tick; tick;
        check("t4.still_alu", 32'(mode), 32'h0);
        check("t4.no_err_yet", 32'(error), 32'h0);
        start = 1'b1; tick; start = 1'b0;
        check("t4.abort_mode", 32'(mode), 32'h3);
        check("t4.abort_busy", 32'(busy), 32'h0);
        check("t4.error", 32'(error), 32'h1);
        tick;
        check("t4.error_sticky", 32'(error), 32'h1);
        check("t4.start_ignored", 32'(mode), 32'h3);
        start = 1'b1; tick; start = 1'b0;
        check("t4.error_cleared", 32'(error), 32'h0);
        check("t4.restart_mode", 32'(mode), 32'h2);

        // Reset while in FETCH_IMM with a push pending
        fetchIn = 32'h4000_0007; fetchPush = 1'b1; tick;
        check("t6.in_imm", 32'(mode), 32'h2);
        check("t6.pcInc", 32'(pcInc), 32'h1);
        fetchIn = 32'h0000_1234; tick;
        pc_base = pc_count;
        #1 rst = 1'b1; #1;
        check_reset_values("t6.async");
        tick;
        check_reset_values("t6.next");
        rst = 1'b0; fetchPush = 1'b0;
        tick;
        check("t6.no_pulse", 32'(pc_count - pc_base), 32'd0);
        check("t6.idle_after", 32'(mode), 32'h3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
